mips_program_loader: RTL and testbench

//  Front-end control stage upstream of the mips core. Consumes a byte stream from a UART

---
 rtl/mips_program_loader_pkg.sv | 27 ++
 rtl/mips_program_loader_if.sv | 24 ++
 rtl/mips_program_loader_byte_word_assembler.sv | 54 +++++
 rtl/mips_program_loader.sv | 172 +++++++++++++++++
 tb/tb_mips_program_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_program_loader_pkg.sv
// Shared definitions for the MIPS program loader: command codes, state encoding, default widths.
package mips_program_loader_pkg;

  localparam int NB_DATA_DEF  = 32;
  localparam int NB_BYTE_DEF  = 8;
  localparam int NB_ADDR_DEF  = 10;
  localparam int NB_STATE_DEF = 3;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_STOP = 8'h48;

  typedef enum logic [NB_STATE_DEF-1:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD_LEN_LO = 3'd1,
    ST_LOAD_LEN_HI = 3'd2,
    ST_LOAD_WORD   = 3'd3,
    ST_RUN         = 3'd4,
    ST_STEP        = 3'd5
  } state_t;

  function automatic logic is_load_state(input state_t st);
    return (st == ST_LOAD_LEN_LO) || (st == ST_LOAD_LEN_HI) || (st == ST_LOAD_WORD);
  endfunction

endpackage

// File: rtl/mips_program_loader_if.sv
// UART byte stream in, instruction-memory write port out; master is the loader.
interface mips_program_loader_if
  import mips_program_loader_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
);
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic               imem_wr_en;
  logic [NB_ADDR-1:0] imem_wr_addr;
  logic [NB_DATA-1:0] imem_wr_data;

  modport master (
    input  rx_data, rx_valid,
    output imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/mips_program_loader_byte_word_assembler.sv
// Shifts bytes in MSB-first and presents a full word with a one-cycle valid strobe.
module byte_word_assembler
  import mips_program_loader_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_byte_valid,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid,
  output logic               o_last_byte
);
  localparam int NB_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_IDX      = (NB_PER_WORD > 1) ? $clog2(NB_PER_WORD) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_PER_WORD - 1);

  logic [NB_IDX-1:0]  byte_idx_r;
  logic [NB_DATA-1:0] shift_r;
  logic               word_valid_r;

  // The shift register itself holds the finished word during the strobe cycle
  assign o_word       = shift_r;
  assign o_word_valid = word_valid_r;
  assign o_last_byte  = i_byte_valid && !i_clear && (byte_idx_r == LAST_IDX);

  // Byte shifting, byte index and word strobe
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      byte_idx_r   <= '0;
      shift_r      <= '0;
      word_valid_r <= 1'b0;
    end else if (i_clear) begin
      byte_idx_r   <= '0;
      shift_r      <= '0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (i_byte_valid) begin
        shift_r <= {shift_r[NB_DATA-NB_BYTE-1:0], i_byte};
        if (byte_idx_r == LAST_IDX) begin
          byte_idx_r   <= '0;
          word_valid_r <= 1'b1;
        end else begin
          byte_idx_r <= byte_idx_r + NB_IDX'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Loads instruction memory from a UART byte stream and drives core reset/enable (run, step, stop).
module mips_program_loader
  import mips_program_loader_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_BYTE  = NB_BYTE_DEF,
  parameter int NB_ADDR  = NB_ADDR_DEF,
  parameter int NB_STATE = NB_STATE_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  mips_program_loader_if.master bus,
  input  logic                 i_halt,
  output logic                 o_mips_reset,
  output logic                 o_mips_enable,
  output logic [NB_DATA-1:0]   o_cycle_count,
  output logic [NB_STATE-1:0]  o_state
);
  localparam int NB_LEN = 2 * NB_BYTE;

  state_t              state_r;
  state_t              state_next_s;
  logic [NB_BYTE-1:0]  len_lo_r;
  logic [NB_LEN-1:0]   len_s;
  logic [NB_LEN-1:0]   words_left_r;
  logic [NB_ADDR-1:0]  word_idx_r;
  logic [NB_DATA-1:0]  cycle_count_r;
  logic                mips_reset_r;
  logic                mips_enable_r;
  logic                mips_reset_next_s;
  logic                mips_enable_next_s;
  logic                load_done_s;
  logic                asm_clear_s;
  logic                asm_byte_valid_s;
  logic [NB_DATA-1:0]  asm_word_s;
  logic                asm_word_valid_s;
  logic                asm_last_byte_s;

  assign len_s            = {bus.rx_data, len_lo_r};
  assign asm_clear_s      = (state_r != ST_LOAD_WORD);
  assign asm_byte_valid_s = bus.rx_valid && (state_r == ST_LOAD_WORD);

  byte_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (asm_clear_s),
    .i_byte       (bus.rx_data),
    .i_byte_valid (asm_byte_valid_s),
    .o_word       (asm_word_s),
    .o_word_valid (asm_word_valid_s),
    .o_last_byte  (asm_last_byte_s)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; commands are only decoded in IDLE, RUN only listens for stop
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == CMD_LOAD)) begin
          state_next_s = ST_LOAD_LEN_LO;
        end else if (bus.rx_valid && (bus.rx_data == CMD_RUN)) begin
          state_next_s = ST_RUN;
        end else if (bus.rx_valid && (bus.rx_data == CMD_STEP)) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD_LEN_LO: begin
        if (bus.rx_valid) begin
          state_next_s = ST_LOAD_LEN_HI;
        end else begin
          state_next_s = ST_LOAD_LEN_LO;
        end
      end
      ST_LOAD_LEN_HI: begin
        if (bus.rx_valid && (len_s == '0)) begin
          state_next_s = ST_IDLE;
        end else if (bus.rx_valid) begin
          state_next_s = ST_LOAD_WORD;
        end else begin
          state_next_s = ST_LOAD_LEN_HI;
        end
      end
      ST_LOAD_WORD: begin
        if (asm_last_byte_s && (words_left_r == NB_LEN'(1))) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_LOAD_WORD;
        end
      end
      ST_RUN: begin
        if (i_halt || (bus.rx_valid && (bus.rx_data == CMD_STOP))) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STEP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it
  always_comb begin
    load_done_s        = is_load_state(state_r) && (state_next_s == ST_IDLE);
    mips_reset_next_s  = is_load_state(state_next_s) || load_done_s;
    mips_enable_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_STEP);
  end

  // Registered core control outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      mips_reset_r  <= 1'b1;
      mips_enable_r <= 1'b0;
    end else begin
      mips_reset_r  <= mips_reset_next_s;
      mips_enable_r <= mips_enable_next_s;
    end
  end

  // Word count, write address and enabled-cycle counter
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      len_lo_r      <= '0;
      words_left_r  <= '0;
      word_idx_r    <= '0;
      cycle_count_r <= '0;
    end else begin
      if ((state_r == ST_LOAD_LEN_LO) && bus.rx_valid) begin
        len_lo_r <= bus.rx_data;
      end
      if ((state_r == ST_LOAD_LEN_HI) && bus.rx_valid) begin
        words_left_r <= len_s;
      end else if (asm_last_byte_s) begin
        words_left_r <= words_left_r - NB_LEN'(1);
      end
      // Address advances after each write and wraps with the memory depth
      if ((state_r == ST_IDLE) && bus.rx_valid && (bus.rx_data == CMD_LOAD)) begin
        word_idx_r <= '0;
      end else if (asm_word_valid_s) begin
        word_idx_r <= word_idx_r + NB_ADDR'(1);
      end
      if (load_done_s) begin
        cycle_count_r <= '0;
      end else if (mips_enable_r) begin
        cycle_count_r <= cycle_count_r + NB_DATA'(1);
      end
    end
  end

  assign bus.imem_wr_en   = asm_word_valid_s;
  assign bus.imem_wr_addr = word_idx_r;
  assign bus.imem_wr_data = asm_word_s;
  assign o_mips_reset     = mips_reset_r;
  assign o_mips_enable    = mips_enable_r;
  assign o_cycle_count    = cycle_count_r;
  assign o_state          = NB_STATE'(state_r);

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: write scoreboard plus status checks at chosen points.
module tb_mips_program_loader;
  localparam int NB_DATA  = 32;
  localparam int NB_BYTE  = 8;
  localparam int NB_ADDR  = 2;
  localparam int NB_STATE = 3;

  typedef struct {
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] data;
  } wr_t;

  logic                clk;
  logic                rst;
  logic                halt;
  logic                mips_reset;
  logic                mips_enable;
  logic [NB_DATA-1:0]  cycle_count;
  logic [NB_STATE-1:0] state;

  int  checks;
  int  errors;
  int  en_cnt;
  int  wr_cnt;
  int  rst_low_cnt;
  bit  in_load;
  wr_t exp_q[$];

  mips_program_loader_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR)) bus ();

  mips_program_loader #(
    .NB_DATA  (NB_DATA),
    .NB_BYTE  (NB_BYTE),
    .NB_ADDR  (NB_ADDR),
    .NB_STATE (NB_STATE)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .bus           (bus),
    .i_halt        (halt),
    .o_mips_reset  (mips_reset),
    .o_mips_enable (mips_enable),
    .o_cycle_count (cycle_count),
    .o_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the write scoreboard and tallies enable / reset activity
  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(bus.imem_wr_addr), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.imem_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.imem_wr_data), 64'(e.data));
      end
    end
    if (mips_enable === 1'b1) en_cnt++;
    if (in_load && (mips_reset !== 1'b1)) rst_low_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_wr(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] wrap_words [5];
    int en_base;
    int wr_base;
    wrap_words[0] = 32'hDEADBEEF;
    wrap_words[1] = 32'h01234567;
    wrap_words[2] = 32'h89ABCDEF;
    wrap_words[3] = 32'hCAFEF00D;
    wrap_words[4] = 32'h0BADC0DE;
    checks = 0; errors = 0; en_cnt = 0; wr_cnt = 0; rst_low_cnt = 0; in_load = 1'b0;
    rst = 1'b0; halt = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_mips_reset", 64'(mips_reset), 64'd1);
    chk("rst_enable", 64'(mips_enable), 64'd0);
    chk("rst_wr_en", 64'(bus.imem_wr_en), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("idle_mips_reset", 64'(mips_reset), 64'd0);
    idle(1);

    // Load two words: 20010005, 00000000
    push_wr(2'd0, 32'h20010005);
    push_wr(2'd1, 32'h00000000);
    send_byte(8'h4C);
    in_load = 1'b1;
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h20010005);
    send_word(32'h00000000);
    @(negedge clk);
    chk("load_end_state", 64'(state), 64'd0);
    chk("load_end_reset_hold", 64'(mips_reset), 64'd1);
    idle(1);
    in_load = 1'b0;
    @(negedge clk);
    chk("load_after_reset", 64'(mips_reset), 64'd0);
    chk("load_reset_held", 64'(rst_low_cnt), 64'd0);
    chk("load_all_written", 64'(exp_q.size()), 64'd0);
    idle(1);

    // Run, halt after 7 low cycles
    en_base = en_cnt;
    send_byte(8'h52);
    idle(7);
    halt = 1'b1;
    idle(1);
    halt = 1'b0;
    idle(2);
    @(negedge clk);
    chk("run_enable_cycles", 64'(en_cnt - en_base), 64'd8);
    chk("run_count", 64'(cycle_count), 64'd8);
    chk("run_state", 64'(state), 64'd0);
    chk("run_enable_off", 64'(mips_enable), 64'd0);
    idle(1);

    // Three single steps
    en_base = en_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53);
      idle(3);
    end
    @(negedge clk);
    chk("step_enable_cycles", 64'(en_cnt - en_base), 64'd3);
    chk("step_count", 64'(cycle_count), 64'd11);
    idle(1);

    // Five words into a four-word memory: the fifth wraps to address 0
    for (int i = 0; i < 5; i++) push_wr(2'(i), wrap_words[i]);
    send_byte(8'h4C);
    in_load = 1'b1;
    send_byte(8'h05); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_word(wrap_words[i]);
    idle(1);
    in_load = 1'b0;
    idle(1);
    @(negedge clk);
    chk("wrap_all_written", 64'(exp_q.size()), 64'd0);
    chk("wrap_state", 64'(state), 64'd0);
    chk("wrap_count_cleared", 64'(cycle_count), 64'd0);
    chk("wrap_reset_held", 64'(rst_low_cnt), 64'd0);
    idle(1);

    // Zero-length load
    wr_base = wr_cnt;
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    @(negedge clk);
    chk("zero_len_no_write", 64'(wr_cnt - wr_base), 64'd0);
    chk("zero_len_state", 64'(state), 64'd0);
    idle(1);

    // Reset in the middle of a two-word load
    send_byte(8'h53);
    idle(2);
    push_wr(2'd0, 32'h12345678);
    send_byte(8'h4C); send_byte(8'h02); send_byte(8'h00);
    send_word(32'h12345678);
    send_byte(8'h9A); send_byte(8'hBC);
    @(negedge clk);
    chk("midload_state", 64'(state), 64'd3);
    chk("midload_count", 64'(cycle_count), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_mips_reset", 64'(mips_reset), 64'd1);
    chk("midrst_wr_en", 64'(bus.imem_wr_en), 64'd0);
    chk("midrst_count", 64'(cycle_count), 64'd0);
    rst = 1'b1;
    idle(2);
    push_wr(2'd0, 32'hCAFEBABE);
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'h00);
    send_word(32'hCAFEBABE);
    idle(2);
    @(negedge clk);
    chk("restart_all_written", 64'(exp_q.size()), 64'd0);
    idle(1);

    // Stop race: ignored bytes in RUN, then 'H' together with halt
    en_base = en_cnt;
    send_byte(8'h52);
    idle(2);
    send_byte(8'h4C); send_byte(8'h53); send_byte(8'h00);
    @(negedge clk);
    chk("race_still_run", 64'(state), 64'd4);
    chk("race_enable_on", 64'(mips_enable), 64'd1);
    halt = 1'b1;
    send_byte(8'h48);
    halt = 1'b0;
    @(negedge clk);
    chk("race_exit_state", 64'(state), 64'd0);
    chk("race_enable_off", 64'(mips_enable), 64'd0);
    idle(2);
    @(negedge clk);
    chk("race_stay_idle", 64'(state), 64'd0);
    chk("race_enable_cycles", 64'(en_cnt - en_base), 64'd6);
    idle(1);

    // Run with halt already high: a single enable cycle
    en_base = en_cnt;
    halt = 1'b1;
    send_byte(8'h52);
    idle(2);
    halt = 1'b0;
    @(negedge clk);
    chk("run_halted_cycles", 64'(en_cnt - en_base), 64'd1);
    chk("run_halted_state", 64'(state), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
